// File: rtl/uart_io_ctrl.sv
// UART responder for the execution stage: 8N1 transmitter with a one-byte hold
// register, and a receiver feeding a small FIFO. Optional macro UART_WORD_READ_EN adds 4-byte word reads.
module uart_io_ctrl #(
  parameter int CLK_PER_BIT  = 868,
  parameter int RX_DEPTH_LOG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_wenable,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
`ifdef UART_WORD_READ_EN
  input  logic        uart_rword,
`endif
  output logic [31:0] uart_rd,
  output logic        uart_rdone,
  output logic        txd,
  input  logic        rxd,
  output logic        uart_err
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int DEPTH = 1 << RX_DEPTH_LOG;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  txState_t r_txState, w_txNext;
  logic [CW-1:0] r_txCnt, w_txCntNext;
  logic [2:0]    r_txIdx, w_txIdxNext;
  logic [7:0]    r_txShift, w_txShiftNext, r_hold;
  logic          r_holdFull, w_txLoad, w_txBitEnd, w_txdComb, w_wdoneComb;
  logic          r_txd, r_wdone;
  logic          w_unusedWd;

  rxState_t r_rxState, w_rxNext;
  logic [CW-1:0] r_rxCnt, w_rxCntNext;
  logic [2:0]    r_rxIdx, w_rxIdxNext;
  logic [7:0]    r_rxShift, w_rxShiftNext;
  logic [1:0]    r_rxSync;
  logic          r_rxPrev, r_rxBreak, w_rxBreakNext, w_rxS, w_rxBitEnd;
  logic          w_rxPushReq, w_rxFrameErr;

  logic [7:0]              r_mem [DEPTH];
  logic [RX_DEPTH_LOG:0]   r_wrPtr, r_rdPtr;
  logic                    w_full, w_empty, w_push, w_pop;
  logic [7:0]              w_rdByte;
  logic                    r_rdPending, r_rdone, r_err;
  logic [31:0]             r_rd;
`ifdef UART_WORD_READ_EN
  logic                    r_rdWord;
  logic [1:0]              r_wordCnt;
  logic [23:0]             r_wordAcc;
`endif

  assign w_unusedWd = ^uart_wd[31:8];
  assign w_txBitEnd = (r_txCnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold     <= '0;
      r_holdFull <= 1'b0;
    end else if (uart_wenable && !r_holdFull) begin
      r_hold     <= uart_wd[7:0];
      r_holdFull <= 1'b1;
    end else if (w_txLoad) begin
      r_holdFull <= 1'b0;
    end
  end

  // Line outputs are registered from the state, so they trail the FSM by one cycle.
  always_comb begin
    w_txNext      = r_txState;
    w_txCntNext   = r_txCnt + 1'b1;
    w_txIdxNext   = r_txIdx;
    w_txShiftNext = r_txShift;
    w_txLoad      = 1'b0;
    w_txdComb     = 1'b1;
    w_wdoneComb   = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        w_txCntNext = '0;
        if (r_holdFull) begin
          w_txLoad = 1'b1;
          w_txNext = TX_START;
        end
      end
      TX_START: begin
        w_txdComb   = 1'b0;
        w_wdoneComb = (r_txCnt == '0);
        if (w_txBitEnd) begin
          w_txCntNext = '0;
          w_txIdxNext = '0;
          w_txNext    = TX_DATA;
        end
      end
      TX_DATA: begin
        w_txdComb = r_txShift[0];
        if (w_txBitEnd) begin
          w_txCntNext   = '0;
          w_txShiftNext = {1'b0, r_txShift[7:1]};
          w_txIdxNext   = r_txIdx + 3'd1;
          if (r_txIdx == 3'd7) w_txNext = TX_STOP;
        end
      end
      TX_STOP: begin
        if (w_txBitEnd) begin
          w_txCntNext = '0;
          if (r_holdFull) begin
            w_txLoad = 1'b1;
            w_txNext = TX_START;
          end else begin
            w_txNext = TX_IDLE;
          end
        end
      end
      default: w_txNext = TX_IDLE;
    endcase
    if (w_txLoad) w_txShiftNext = r_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txIdx   <= '0;
      r_txShift <= '0;
      r_txd     <= 1'b1;
      r_wdone   <= 1'b0;
    end else begin
      r_txState <= w_txNext;
      r_txCnt   <= w_txCntNext;
      r_txIdx   <= w_txIdxNext;
      r_txShift <= w_txShiftNext;
      r_txd     <= w_txdComb;
      r_wdone   <= w_wdoneComb;
    end
  end

  assign w_rxS      = r_rxSync[1];
  assign w_rxBitEnd = (r_rxCnt == BIT_LAST);

  // After a framing error the receiver parks in STOP until the line returns high.
  always_comb begin
    w_rxNext      = r_rxState;
    w_rxCntNext   = r_rxCnt + 1'b1;
    w_rxIdxNext   = r_rxIdx;
    w_rxShiftNext = r_rxShift;
    w_rxBreakNext = r_rxBreak;
    w_rxPushReq   = 1'b0;
    w_rxFrameErr  = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        w_rxCntNext = '0;
        if (r_rxPrev && !w_rxS) w_rxNext = RX_START;
      end
      RX_START: begin
        if (r_rxCnt == HALF_LAST) begin
          w_rxCntNext = '0;
          w_rxIdxNext = '0;
          w_rxNext    = w_rxS ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rxBitEnd) begin
          w_rxCntNext   = '0;
          w_rxShiftNext = {w_rxS, r_rxShift[7:1]};
          w_rxIdxNext   = r_rxIdx + 3'd1;
          if (r_rxIdx == 3'd7) w_rxNext = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rxBreak) begin
          w_rxCntNext = '0;
          if (w_rxS) begin
            w_rxBreakNext = 1'b0;
            w_rxNext      = RX_IDLE;
          end
        end else if (w_rxBitEnd) begin
          w_rxCntNext = '0;
          if (w_rxS) begin
            w_rxPushReq = 1'b1;
            w_rxNext    = RX_IDLE;
          end else begin
            w_rxFrameErr  = 1'b1;
            w_rxBreakNext = 1'b1;
          end
        end
      end
      default: w_rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxState <= RX_IDLE;
      r_rxCnt   <= '0;
      r_rxIdx   <= '0;
      r_rxShift <= '0;
      r_rxBreak <= 1'b0;
      r_rxSync  <= 2'b11;
      r_rxPrev  <= 1'b1;
    end else begin
      r_rxState <= w_rxNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxIdx   <= w_rxIdxNext;
      r_rxShift <= w_rxShiftNext;
      r_rxBreak <= w_rxBreakNext;
      r_rxSync  <= {r_rxSync[0], rxd};
      r_rxPrev  <= w_rxS;
    end
  end

  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[RX_DEPTH_LOG] != r_rdPtr[RX_DEPTH_LOG]) &&
                    (r_wrPtr[RX_DEPTH_LOG-1:0] == r_rdPtr[RX_DEPTH_LOG-1:0]);
  assign w_push   = w_rxPushReq && !w_full;
  assign w_pop    = r_rdPending && !w_empty;
  assign w_rdByte = r_mem[r_rdPtr[RX_DEPTH_LOG-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[RX_DEPTH_LOG-1:0]] <= r_rxShift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Word reads accumulate popped bytes big-endian until the fourth one arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPending <= 1'b0;
      r_rdone     <= 1'b0;
      r_rd        <= '0;
`ifdef UART_WORD_READ_EN
      r_rdWord    <= 1'b0;
      r_wordCnt   <= '0;
      r_wordAcc   <= '0;
`endif
    end else begin
      r_rdone <= 1'b0;
      if (uart_renable && !r_rdPending) begin
        r_rdPending <= 1'b1;
`ifdef UART_WORD_READ_EN
        r_rdWord    <= uart_rword;
`endif
      end
      if (w_pop) begin
`ifdef UART_WORD_READ_EN
        if (r_rdWord && r_wordCnt != 2'd3) begin
          r_wordAcc <= {r_wordAcc[15:0], w_rdByte};
          r_wordCnt <= r_wordCnt + 2'd1;
        end else begin
          r_rd        <= r_rdWord ? {r_wordAcc, w_rdByte} : {24'h0, w_rdByte};
          r_rdone     <= 1'b1;
          r_rdPending <= 1'b0;
          r_wordCnt   <= '0;
        end
`else
        r_rd        <= {24'h0, w_rdByte};
        r_rdone     <= 1'b1;
        r_rdPending <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((uart_wenable && r_holdFull) || (uart_renable && r_rdPending) ||
                 w_rxFrameErr || (w_rxPushReq && w_full)) begin
      r_err <= 1'b1;
    end
  end

  assign txd        = r_txd;
  assign uart_wdone = r_wdone;
  assign uart_rd    = r_rd;
  assign uart_rdone = r_rdone;
  assign uart_err   = r_err;

endmodule

// File: doc/uart_io_ctrl.md
Name: uart_io_ctrl

Overview:
- Responder side of the execution stage's UART handshake (uart_wenable/uart_wdone for OUTB, uart_renable/uart_rdone/uart_rd for input instructions).
- Serializes output bytes onto txd and deserializes rxd into a small receive FIFO.
- Answers each read request with the oldest received byte.
- Sits between the core and the board UART pins; one clock domain, 8N1 framing.

Parameters:
- CLK_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be ≥ 4.
- RX_DEPTH_LOG, 4, log2 of receive FIFO depth (16 entries).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- uart_wenable  input  1  one-cycle write request
- uart_wd  input  32  write data; only bits [7:0] are transmitted
- uart_wdone  output  1  one-cycle pulse: write byte accepted into shifter
- uart_renable  input  1  one-cycle read request
- uart_rd  output  32  read data, {24'h0, byte}
- uart_rdone  output  1  one-cycle pulse: uart_rd valid
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous
- uart_err  output  1  sticky protocol/line error flag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: uart_wdone=0, uart_rdone=0, uart_rd=0, txd=1, uart_err=0. Both FSMs return to IDLE, FIFO is emptied, and pending flags are cleared.
- Reset mid-frame aborts the frame; txd is 1 from the next edge.

TX FSM (IDLE, START, DATA, STOP):
- Each bit lasts CLK_PER_BIT cycles; bits are sent LSB first; a 3-bit index counts data bits.
- A one-byte hold register sits in front of the shifter.
- uart_wenable at edge T with hold empty: uart_wd[7:0] latched into hold.
- When hold is full and the FSM is IDLE, the byte moves to the shifter, the FSM enters START, txd=0, and uart_wdone pulses in the same cycle. With an idle line, uart_wenable sampled at T gives txd=0 and uart_wdone=1 during cycle T+2.
- After STOP (txd=1 for CLK_PER_BIT cycles), the FSM goes to IDLE. If hold is full, it goes directly to START the following cycle (back-to-back frames, no extra idle bit).
- uart_wenable while hold is full: the write is ignored and uart_err is set.

RX FSM (IDLE, START, DATA, STOP):
- rxd passes through a 2-flop synchronizer.
- IDLE: a synchronized falling edge moves the FSM to START.
- START: sample at CLK_PER_BIT/2. If the line is high, treat it as a glitch and return to IDLE. Otherwise sample every CLK_PER_BIT thereafter: 8 data bits, LSB first, then the stop bit.
- Stop bit = 1: push the byte into the FIFO.
- Stop bit = 0 (framing error): drop the byte, set uart_err, and wait for rxd=1 before returning to IDLE.
- FIFO full at push: drop the byte and set uart_err.

Read side:
- uart_renable sets rd_pending.
- rd_pending and FIFO non-empty: pop, uart_rd <= {24'h0, byte}, uart_rdone=1 for one cycle, clear rd_pending.
- If the FIFO is non-empty when uart_renable is sampled at edge T, uart_rdone is high during cycle T+1.
- If the FIFO is empty, the response comes the cycle after the next push.
- uart_rd holds its value until the next uart_rdone.
- uart_renable while rd_pending is set: ignored, uart_err set.
- Push and pop in the same cycle: both happen. FIFO count is unchanged, and an empty FIFO with pending read does not forward the byte combinationally (one-cycle latency).

Pointers and errors:
- FIFO pointers are RX_DEPTH_LOG+1 bits and wrap naturally. Full = MSBs differ and low bits equal.
- uart_err is cleared only by rst.

Optional Feature:
- Macro UART_WORD_READ_EN.
- Defined: adds input uart_rword (1 bit), sampled with uart_renable.
  - When uart_rword=1, the read pops 4 bytes, assembled big-endian (first byte to [31:24]). uart_rdone pulses only after the 4th pop.
  - When uart_rword=0, behaviour is the byte read above.
  - Bytes are popped as they become available; partial assembly persists across waits.
- Undefined: no uart_rword port; all reads are byte reads.

Test Plan:
- CLK_PER_BIT=4, idle line; uart_wenable with uart_wd=32'h0000_01A5 -> uart_wdone during T+2. txd shows 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
- Two writes 0x41 then 0x42, second issued right after the first uart_wdone -> 20 bits back-to-back, with no idle gap between the first frame's stop bit and the second frame's start bit. A third uart_wenable before the second uart_wdone -> uart_err=1, byte dropped.
- Drive rxd frame 0x3C, then pulse uart_renable -> uart_rdone next cycle, uart_rd=32'h0000_003C. Issue uart_renable with empty FIFO, then send 0x7E -> uart_rdone the cycle after the push, uart_rd=32'h0000_007E.
- Send 17 frames (0x00..0x10) with no reads -> uart_err=1. 16 reads return 0x00..0x0F, then a read waits.
- Frame 0x55 with stop bit 0 -> uart_err=1, nothing pushed. A 1-cycle low glitch on rxd -> no push, no error.
- Assert rst mid-TX-frame and with 3 bytes queued -> txd=1 next cycle, all outputs at reset values. A read afterwards waits for new data. With UART_WORD_READ_EN: receive 0xDE,0xAD,0xBE,0xEF, then word read -> uart_rd=32'hDEAD_BEEF.
